// File: rtl/vga_fb_pkg.sv
// ---------------------------------------------------------------------------
// vga_fb_pkg
// Shared constants and types for the VGA framebuffer controller:
//   - MMIO register addresses on the OTTER IOBUS
//   - framebuffer geometry (80x60 pixels) and port widths
//   - controller state encoding
//   - write-queue entry layout {addr, color}
// ---------------------------------------------------------------------------
package vga_fb_pkg;

    localparam int NPIX  = 4800;   // 80 x 60 pixels
    localparam int FB_AW = 13;     // framebuffer address width
    localparam int FB_DW = 8;      // RGB 3-3-2 pixel width

    localparam logic [31:0] MMIO_ADDR   = 32'h1100_0120;
    localparam logic [31:0] MMIO_COLOR  = 32'h1100_0140;
    localparam logic [31:0] MMIO_READ   = 32'h1100_0160;
    localparam logic [31:0] MMIO_FILL   = 32'h1100_0180;
    localparam logic [31:0] MMIO_STATUS = 32'h1100_01A0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FILL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [FB_AW-1:0] addr;
        logic [FB_DW-1:0] color;
    } fb_entry_t;

endpackage

// File: rtl/vga_fb_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_fb_ctrl_if
// Bundles the IOBUS side and the framebuffer-port side of the controller.
//   master : CPU/board side - drives IOBUS_ADDR/OUT/WR and FB_RD,
//            observes RDATA, FB_WA, FB_WD, FB_WE, BUSY
//   slave  : the controller - the mirror image
// ---------------------------------------------------------------------------
interface vga_fb_ctrl_if #(
    parameter int AW = vga_fb_pkg::FB_AW,
    parameter int DW = vga_fb_pkg::FB_DW
);
    logic [31:0]   IOBUS_ADDR;
    logic [31:0]   IOBUS_OUT;
    logic          IOBUS_WR;
    logic [31:0]   RDATA;
    logic [AW-1:0] FB_WA;
    logic [DW-1:0] FB_WD;
    logic          FB_WE;
    logic [DW-1:0] FB_RD;
    logic          BUSY;

    modport master (
        output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, FB_RD,
        input  RDATA, FB_WA, FB_WD, FB_WE, BUSY
    );

    modport slave (
        input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, FB_RD,
        output RDATA, FB_WA, FB_WD, FB_WE, BUSY
    );
endinterface

// File: rtl/fb_wr_queue.sv
// ---------------------------------------------------------------------------
// fb_wr_queue
// Synchronous FIFO holding pending CPU pixel writes.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/wdata_i: enqueue; accepted when not full or when popping
//   pop_i/rdata_o : dequeue; rdata_o shows the head entry combinationally
//   full_o/empty_o/count_o : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module fb_wr_queue #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  T                         wdata_i,
    output T                         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // When full, a simultaneous pop frees the head slot, which is exactly
    // the slot the write pointer targets, so the push can land this edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    // NOTE: state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/vga_fb_ctrl.sv
// ---------------------------------------------------------------------------
// vga_fb_ctrl
// Owns the single framebuffer port and shares it between queued CPU pixel
// writes and a clear-screen fill engine.
//   CLK : 50 MHz CPU clock
//   RST : synchronous, active-low reset
//   bus : IOBUS_ADDR/OUT/WR in, RDATA out (CPU MMIO)
//         FB_WA/FB_WD/FB_WE out, FB_RD in (framebuffer port)
//         BUSY out (fill pending/active or queue non-empty)
// ---------------------------------------------------------------------------
module vga_fb_ctrl
    import vga_fb_pkg::*;
#(
    parameter int NPIX   = vga_fb_pkg::NPIX,
    parameter int AW     = vga_fb_pkg::FB_AW,   // must match the entry type
    parameter int DW     = vga_fb_pkg::FB_DW,   // must match the entry type
    parameter int QDEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    vga_fb_ctrl_if.slave  bus
);
    localparam int            QCW      = $clog2(QDEPTH) + 1;
    localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
    localparam logic [AW-1:0] NPIX_A   = AW'(NPIX);

    state_e         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;            // CPU pixel pointer
    logic [AW-1:0]  fill_addr_q, fill_addr_d;
    logic [DW-1:0]  fill_color_q, fill_color_d; // color of the running fill
    logic [DW-1:0]  req_color_q, req_color_d;   // color of the requested fill
    logic           fill_req_q, fill_req_d;
    logic           ovf_q, ovf_d;

    logic           wr_addr, wr_color, wr_fill, wr_status;
    logic           q_push, q_pop, q_full, q_empty;
    logic [QCW-1:0] q_count;
    fb_entry_t      q_wdata, q_rdata;
    logic           start_fill;
    logic           busy;
    logic           unused_iobus;

    // -------------------------------------------------------------------
    // Register decode
    // -------------------------------------------------------------------
    assign wr_addr   = bus.IOBUS_WR && (bus.IOBUS_ADDR == MMIO_ADDR);
    assign wr_color  = bus.IOBUS_WR && (bus.IOBUS_ADDR == MMIO_COLOR);
    assign wr_fill   = bus.IOBUS_WR && (bus.IOBUS_ADDR == MMIO_FILL);
    assign wr_status = bus.IOBUS_WR && (bus.IOBUS_ADDR == MMIO_STATUS);

    // Upper data bits carry no meaning for this block.
    assign unused_iobus = ^bus.IOBUS_OUT[31:AW];

    // -------------------------------------------------------------------
    // Write queue
    // -------------------------------------------------------------------
    assign q_pop   = (state_q == DRAIN);
    assign q_push  = wr_color && (!q_full || q_pop);
    assign q_wdata = '{addr: addr_q, color: bus.IOBUS_OUT[DW-1:0]};

    fb_wr_queue #(
        .DEPTH (QDEPTH),
        .T     (fb_entry_t)
    ) u_queue (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .wdata_i (q_wdata),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    // -------------------------------------------------------------------
    // CPU-visible registers
    // -------------------------------------------------------------------
    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        addr_d      = addr_q;
        req_color_d = req_color_q;
        fill_req_d  = fill_req_q;
        ovf_d       = ovf_q;

        // A dropped COLOR write still advances the pointer.
        if (wr_addr) begin
            addr_d = bus.IOBUS_OUT[AW-1:0];
        end else if (wr_color) begin
            addr_d = (addr_q == LAST_PIX) ? '0 : addr_q + AW'(1);
        end

        if (wr_status) begin
            ovf_d = 1'b0;
        end else if (wr_color && !q_push) begin
            ovf_d = 1'b1;
        end

        // A request arriving in the same cycle the FSM consumes the previous
        // one must survive, so the new write is applied last.
        if (start_fill) fill_req_d = 1'b0;
        if (wr_fill) begin
            fill_req_d  = 1'b1;
            req_color_d = bus.IOBUS_OUT[DW-1:0];
        end
    end

    // -------------------------------------------------------------------
    // Port-owner FSM and fill counter
    // -------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        fill_addr_d  = fill_addr_q;
        fill_color_d = fill_color_q;
        start_fill   = 1'b0;

        case (state_q)
            IDLE: begin
                if (fill_req_q)    start_fill = 1'b1;
                else if (!q_empty) state_d    = DRAIN;
            end
            DRAIN: begin
                // The head is popped this cycle whatever happens next.
                if (fill_req_q) begin
                    start_fill = 1'b1;
                end else if ((q_count == QCW'(1)) && !q_push) begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (fill_req_q) begin
                    start_fill = 1'b1;
                end else if (fill_addr_q == LAST_PIX) begin
                    state_d = (q_empty && !q_push) ? IDLE : DRAIN;
                end else begin
                    fill_addr_d = fill_addr_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_fill) begin
            state_d      = FILL;
            fill_addr_d  = '0;
            fill_color_d = req_color_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            fill_addr_q  <= '0;
            fill_color_q <= '0;
            req_color_q  <= '0;
            fill_req_q   <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            fill_addr_q  <= fill_addr_d;
            fill_color_q <= fill_color_d;
            req_color_q  <= req_color_d;
            fill_req_q   <= fill_req_d;
            ovf_q        <= ovf_d;
        end
    end

    // -------------------------------------------------------------------
    // Framebuffer port mux and read-back
    // -------------------------------------------------------------------
    assign busy     = (state_q != IDLE) || !q_empty || fill_req_q;
    assign bus.BUSY = busy;

    always_comb begin
        bus.FB_WA = addr_q;
        bus.FB_WD = '0;
        bus.FB_WE = 1'b0;
        case (state_q)
            DRAIN: begin
                // Out-of-range entries still consume a pop but never write.
                bus.FB_WA = q_rdata.addr;
                bus.FB_WD = q_rdata.color;
                bus.FB_WE = (q_rdata.addr < NPIX_A);
            end
            FILL: begin
                bus.FB_WA = fill_addr_q;
                bus.FB_WD = fill_color_q;
                bus.FB_WE = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.RDATA = '0;
        if (bus.IOBUS_ADDR == MMIO_READ) begin
            bus.RDATA = {{(32-DW){1'b0}}, bus.FB_RD};
        end else if (bus.IOBUS_ADDR == MMIO_STATUS) begin
            bus.RDATA = {29'b0, ovf_q, q_full, busy};
        end
    end

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_ctrl
// Directed and randomized checks of vga_fb_ctrl against a behavioural model
// of the pixel pointer, the expected framebuffer image and the expected
// stream of framebuffer writes.
// ---------------------------------------------------------------------------
module tb_vga_fb_ctrl;
    import vga_fb_pkg::*;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int QD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    vga_fb_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    vga_fb_ctrl #(
        .NPIX   (NPIX),
        .AW     (AW),
        .DW     (DW),
        .QDEPTH (QD)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct {
        int addr;
        int data;
    } pix_t;

    wr_t           obs[$];
    pix_t          expq[$];
    logic [DW-1:0] fbmem  [1 << AW];
    logic [DW-1:0] exp_fb [NPIX];

    // Framebuffer memory model: writes land on the clock edge, read is async.
    assign bus.FB_RD = fbmem[bus.FB_WA];

    always @(posedge clk) begin
        if (bus.FB_WE === 1'b1) begin
            obs.push_back('{int'(bus.FB_WA), int'(bus.FB_WD), cyc});
            fbmem[bus.FB_WA] = bus.FB_WD;
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        total++;
        assert (obs_v === exp_v) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs_v, exp_v);
        end
    endtask

    // Entered just after a negedge; the write is sampled on the next posedge
    // and the task returns on the following negedge.
    task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
        bus.IOBUS_ADDR = a;
        bus.IOBUS_OUT  = d;
        bus.IOBUS_WR   = 1'b1;
        @(negedge clk);
        bus.IOBUS_WR   = 1'b0;
        bus.IOBUS_ADDR = '0;
    endtask

    task automatic cpu_rd(input logic [31:0] a, output logic [31:0] d);
        bus.IOBUS_ADDR = a;
        #1;
        d = bus.RDATA;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus.BUSY === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, bus.BUSY}, 32'd0);
    endtask

    function automatic int next_ptr(input int p);
        return (p == NPIX - 1) ? 0 : (p + 1) % (1 << AW);
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] d;
        logic [7:0]  cols[6];
        int          ptr;
        int          t0;
        int          nerr;
        int          a;
        int          r;
        bit          found;

        for (int i = 0; i < (1 << AW); i++) fbmem[i] = '0;
        for (int i = 0; i < NPIX; i++) exp_fb[i] = '0;
        bus.IOBUS_ADDR = '0;
        bus.IOBUS_OUT  = '0;
        bus.IOBUS_WR   = 1'b0;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("rst_we",    {31'b0, bus.FB_WE}, 32'd0);
        check("rst_wa",    32'(bus.FB_WA),     32'd0);
        check("rst_wd",    32'(bus.FB_WD),     32'd0);
        check("rst_busy",  {31'b0, bus.BUSY},  32'd0);
        check("rst_rdata", bus.RDATA,          32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_rd(MMIO_STATUS, rd);
        check("rst_status", rd, 32'd0);

        // ---------------- single write ----------------
        obs.delete();
        cpu_wr(MMIO_ADDR, 32'd10);
        cpu_wr(MMIO_COLOR, 32'h0000_00E0);
        @(negedge clk);
        check("single_we",   {31'b0, bus.FB_WE}, 32'd1);
        check("single_wa",   32'(bus.FB_WA),     32'd10);
        check("single_wd",   32'(bus.FB_WD),     32'hE0);
        check("single_busy", {31'b0, bus.BUSY},  32'd1);
        @(negedge clk);
        check("single_we_off", {31'b0, bus.FB_WE}, 32'd0);
        check("single_idle",   {31'b0, bus.BUSY},  32'd0);
        check("single_ptr",    32'(bus.FB_WA),     32'd11);
        check("single_count",  obs.size(),         32'd1);
        exp_fb[10] = 8'hE0;

        // ---------------- address wrap ----------------
        obs.delete();
        cpu_wr(MMIO_ADDR, 32'(NPIX - 1));
        cpu_wr(MMIO_COLOR, 32'h1C);
        cpu_wr(MMIO_COLOR, 32'h03);
        wait_idle("wrap_idle", 20);
        check("wrap_count", obs.size(), 32'd2);
        if (obs.size() == 2) begin
            check("wrap_w0",   32'(obs[0].addr * 256 + obs[0].data), 32'((NPIX - 1) * 256 + 8'h1C));
            check("wrap_w1",   32'(obs[1].addr * 256 + obs[1].data), 32'h03);
            check("wrap_b2b",  32'(obs[1].cyc - obs[0].cyc),         32'd1);
        end
        check("wrap_ptr", 32'(bus.FB_WA), 32'd1);
        exp_fb[NPIX - 1] = 8'h1C;
        exp_fb[0]        = 8'h03;

        // ---------------- randomized COLOR/ADDR traffic ----------------
        obs.delete();
        expq.delete();
        ptr = 1;
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, NPIX - 1)
                                                : NPIX - 3 + $urandom_range(0, 5);
                d = $urandom;
                d[AW-1:0] = AW'(a);
                ptr = a;
                cpu_wr(MMIO_ADDR, d);
            end else if (r < 8) begin
                d = $urandom;
                if (ptr < NPIX) begin
                    expq.push_back('{ptr, int'(d[7:0])});
                    exp_fb[ptr] = d[7:0];
                end
                ptr = next_ptr(ptr);
                cpu_wr(MMIO_COLOR, d);
            end else begin
                @(negedge clk);
            end
        end
        wait_idle("rand_idle", 50);
        check("rand_count", obs.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            check($sformatf("rand_w%0d", i), 32'(obs[i].addr * 256 + obs[i].data),
                  32'(expq[i].addr * 256 + expq[i].data));
        end
        check("rand_ptr", 32'(bus.FB_WA), 32'(ptr));
        cpu_rd(MMIO_STATUS, rd);
        check("rand_status", rd, 32'd0);

        for (int k = 0; k < 6; k++) begin
            a = (k < expq.size() && k < 3) ? expq[k].addr : $urandom_range(0, NPIX - 1);
            cpu_wr(MMIO_ADDR, 32'(a));
            cpu_rd(MMIO_READ, rd);
            check($sformatf("read_%0d", a), rd, {24'b0, exp_fb[a]});
        end

        // ---------------- full-screen fill ----------------
        obs.delete();
        cpu_wr(MMIO_FILL, 32'h0000_0000);
        t0 = cyc;
        repeat (NPIX) @(negedge clk);
        check("fill_last_we",   {31'b0, bus.FB_WE}, 32'd1);
        check("fill_last_wa",   32'(bus.FB_WA),     32'(NPIX - 1));
        check("fill_last_busy", {31'b0, bus.BUSY},  32'd1);
        @(negedge clk);
        check("fill_done_busy", {31'b0, bus.BUSY},  32'd0);
        check("fill_done_we",   {31'b0, bus.FB_WE}, 32'd0);
        check("fill_count", obs.size(), 32'(NPIX));
        nerr = 0;
        foreach (obs[i]) begin
            if (obs[i].addr != i || obs[i].data != 0 || obs[i].cyc != t0 + 1 + i) nerr++;
        end
        check("fill_seq", 32'(nerr), 32'd0);
        for (int i = 0; i < NPIX; i++) exp_fb[i] = 8'h00;

        // ---------------- fill restart ----------------
        obs.delete();
        cpu_wr(MMIO_FILL, 32'h0000_00FF);
        t0 = cyc;
        repeat (99) @(negedge clk);
        cpu_wr(MMIO_FILL, 32'h0000_0003);
        wait_idle("restart_idle", NPIX + 200);
        check("restart_count", obs.size(), 32'(100 + NPIX));
        nerr = 0;
        foreach (obs[i]) begin
            if (i < 100) begin
                if (obs[i].addr != i || obs[i].data != 8'hFF) nerr++;
            end else begin
                if (obs[i].addr != i - 100 || obs[i].data != 8'h03) nerr++;
            end
            if (obs[i].cyc != t0 + 1 + i) nerr++;
        end
        check("restart_seq", 32'(nerr), 32'd0);
        for (int i = 0; i < NPIX; i++) exp_fb[i] = 8'h03;

        // ---------------- queue overflow during fill ----------------
        obs.delete();
        cpu_wr(MMIO_FILL, 32'h0000_005A);
        t0 = cyc;
        cpu_wr(MMIO_ADDR, 32'd200);
        for (int i = 0; i < 6; i++) begin
            cols[i] = 8'(8'h20 + 8'(i * 17));
            cpu_wr(MMIO_COLOR, {24'hABCDEF, cols[i]});
        end
        cpu_rd(MMIO_STATUS, rd);
        check("ovf_status_busy", rd, 32'd7);
        wait_idle("ovf_idle", NPIX + 200);
        check("ovf_count", obs.size(), 32'(NPIX + QD));
        nerr = 0;
        for (int i = 0; i < NPIX && i < obs.size(); i++) begin
            if (obs[i].addr != i || obs[i].data != 8'h5A) nerr++;
        end
        check("ovf_fill_seq", 32'(nerr), 32'd0);
        for (int i = 0; i < QD && NPIX + i < obs.size(); i++) begin
            check($sformatf("ovf_drain%0d", i), 32'(obs[NPIX + i].addr * 256 + obs[NPIX + i].data),
                  32'((200 + i) * 256 + cols[i]));
        end
        if (obs.size() > NPIX) check("ovf_drain_start", 32'(obs[NPIX].cyc), 32'(t0 + NPIX + 1));
        check("ovf_ptr", 32'(bus.FB_WA), 32'd206);
        cpu_rd(MMIO_STATUS, rd);
        check("ovf_sticky", rd, 32'd4);
        cpu_wr(MMIO_STATUS, 32'd0);
        cpu_rd(MMIO_STATUS, rd);
        check("ovf_cleared", rd, 32'd0);
        for (int i = 0; i < NPIX; i++) exp_fb[i] = 8'h5A;
        for (int i = 0; i < QD; i++) exp_fb[200 + i] = cols[i];
        cpu_wr(MMIO_ADDR, 32'd203);
        cpu_rd(MMIO_READ, rd);
        check("ovf_read_kept", rd, {24'b0, exp_fb[203]});
        cpu_wr(MMIO_ADDR, 32'd204);
        cpu_rd(MMIO_READ, rd);
        check("ovf_read_dropped", rd, {24'b0, exp_fb[204]});

        // ---------------- reset mid-fill ----------------
        obs.delete();
        cpu_wr(MMIO_FILL, 32'h0000_0077);
        cpu_wr(MMIO_ADDR, 32'd300);
        cpu_wr(MMIO_COLOR, 32'h11);
        cpu_wr(MMIO_COLOR, 32'h22);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (bus.FB_WE === 1'b1 && bus.FB_WA == AW'(2000)) found = 1'b1;
        end
        check("midrst_reached", {31'b0, found}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_we",   {31'b0, bus.FB_WE}, 32'd0);
        check("midrst_wa",   32'(bus.FB_WA),     32'd0);
        check("midrst_wd",   32'(bus.FB_WD),     32'd0);
        check("midrst_busy", {31'b0, bus.BUSY},  32'd0);
        if (obs.size() > 0) check("midrst_last", 32'(obs[obs.size() - 1].addr), 32'd2000);
        obs.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_writes", obs.size(), 32'd0);
        cpu_rd(MMIO_STATUS, rd);
        check("midrst_status", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
